uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (one-cycle start strobe, busy flag high while the frame shifts) between NUM_REQ byte-sized requesters.
- Arbitration is round-robin.
- The block launches each frame and detects completion, a start timeout, and a configurable inter-frame gap.
- It sits between client logic (switch/button front-ends, status reporters) and the transmitter in the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, payload width per requester
GAP_CYCLES, 16, idle clk cycles enforced after every frame (0 allowed)
START_TIMEOUT, 8, max clk cycles from start strobe until tx_busy must rise (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
req  input  NUM_REQ  per-requester transmit request, level; hold until ack or err
req_data  input  NUM_REQ*DATA_W  payload; requester i uses bits [i*DATA_W +: DATA_W]; hold stable while req high
ack  output  NUM_REQ  one-cycle pulse to the granted requester when its frame completed
err  output  NUM_REQ  one-cycle pulse to the granted requester on start timeout
tx_start  output  1  one-cycle start strobe to transmitter
tx_data  output  DATA_W  byte to transmitter, registered
tx_busy  input  1  transmitter busy flag
active_id  output  clog2(NUM_REQ)  index of current or last granted requester
ctrl_busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. On reset (rst==0 at a clock edge):
  - state=IDLE; ack, err, tx_start, tx_data, active_id and ctrl_busy are all 0.
  - The round-robin pointer is set so requester 0 has top priority.
  - Reset mid-frame abandons the transaction; no ack or err is issued for it.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Arbitrates only when tx_busy==0 and |req. This covers a transmitter still shifting after reset.
  - Winner: the first asserted req searching upward from (last_grant+1) mod NUM_REQ, wrapping.
  - At that edge, latch active_id and tx_data=req_data[winner]; go to LAUNCH.
- LAUNCH:
  - Lasts exactly 1 cycle, with tx_start=1.
  - Latency: req sampled high in IDLE at edge k gives tx_start high during cycle k+1.
  - Go to WAIT_BUSY. The timeout counter is cleared.
- WAIT_BUSY:
  - tx_busy==1: go to WAIT_DONE.
  - Otherwise increment the counter. When START_TIMEOUT cycles have elapsed since the end of LAUNCH without busy, pulse err[active_id] for 1 cycle and go to GAP.
- WAIT_DONE: on the first cycle tx_busy==0, pulse ack[active_id] for 1 cycle and go to GAP.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - With GAP_CYCLES==0, GAP lasts exactly 1 cycle (the ack/err cycle) before IDLE.
- last_grant updates to active_id on the ack or err cycle. The next arbitration therefore starts after it, which guarantees no starvation.
- tx_data is held stable from LAUNCH through the end of WAIT_DONE and is not cleared in GAP.
- A requester dropping req while granted has no effect: the frame completes and ack is still pulsed. Its data is already latched.
- A requester whose req stays high after ack is treated as a new request. It wins again only if no other req is pending.
- ack and err are never both high, and never high for more than one requester at once.
- Simultaneous events:
  - tx_busy rising in the same cycle the timeout expires counts as success: go to WAIT_DONE, no err.
  - New reqs arriving during any non-IDLE state wait for IDLE.
- If the transmitter raises busy for only 1 cycle, that is still a valid frame: WAIT_DONE is entered and ack follows when busy drops.

Test Plan:
1. Single request: req=4'b0001, req_data[7:0]=8'hB5 → tx_start pulse 1 cycle after sampling; tx_data=8'hB5; model busy for 10 cycles → ack[0] single pulse the cycle after busy falls; ctrl_busy low after 16 gap cycles.
2. Round-robin: req=4'b1111 held, data 8'h10,8'h21,8'h32,8'h43 → frames sent in order 10,21,32,43, then repeat 10; each ack goes to the matching index; gap ≥16 cycles between consecutive tx_start.
3. Fairness: req0 held continuously, req2 asserted mid-frame 0 → next frame is requester 2, not 0; active_id=2.
4. Timeout: tx_busy tied 0, req=4'b0100 → err[2] pulse exactly START_TIMEOUT cycles after LAUNCH ends; no ack; next arbitration starts after the gap.
5. Reset mid-frame: rst=0 during WAIT_DONE → next cycle all outputs 0, state IDLE. After release, tx_busy still 1 (transmitter finishing) → no tx_start until busy is 0; then requester 0 wins over a pending req3.
6. GAP_CYCLES=0 build: back-to-back requests → next tx_start exactly 2 cycles after the ack cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-sized requesters using
// round-robin arbitration. For each granted request the block latches the
// payload, issues a one-cycle start strobe, and waits for the transmitter's
// busy flag to rise and then fall. Completion is reported with a one-cycle
// ack. A missing busy response within START_TIMEOUT cycles is reported with a
// one-cycle err. After every frame a gap of GAP_CYCLES idle cycles is enforced.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low, sampled on the rising clk edge
//   req        per-requester request level, held until ack or err
//   req_data   packed payloads, requester i owns bits [i*DATA_W +: DATA_W]
//   ack        one-cycle completion pulse to the granted requester
//   err        one-cycle start-timeout pulse to the granted requester
//   tx_start   one-cycle start strobe to the transmitter
//   tx_data    registered byte presented to the transmitter
//   tx_busy    transmitter busy flag
//   active_id  index of the current or last granted requester
//   ctrl_busy  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 8,
  localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           active_id,
  output logic                      ctrl_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  // One counter serves both the start timeout and the inter-frame gap.
  localparam int unsigned CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]         state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [ID_W-1:0]    active_id_q,  active_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  tx_data_q,    tx_data_d;
  logic               tx_start_q,   tx_start_d;
  logic [NUM_REQ-1:0] ack_q,        ack_d;
  logic [NUM_REQ-1:0] err_q,        err_d;
  logic               ctrl_busy_q,  ctrl_busy_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [DATA_W-1:0]  grant_data;

  // Round-robin search: first pass covers indices above the last grant, the
  // second pass wraps around to index 0 up to and including the last grant.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values just computed; clocked blocks use '<=' so all registers update
  // together from the pre-edge values.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!grant_found && req[i] && (i > int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
        grant_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!grant_found && req[i] && (i <= int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
        grant_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_id_d  = active_id_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    ack_d        = '0;
    err_d        = '0;

    case (state_q)
      S_IDLE: begin
        // A transmitter still shifting (e.g. after a reset) blocks arbitration.
        if (!tx_busy && grant_found) begin
          state_d     = S_LAUNCH;
          active_id_d = grant_id;
          tx_data_d   = grant_data;
          tx_start_d  = 1'b1;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end

      S_WAIT_BUSY: begin
        // Busy is tested first so a rise on the expiry cycle still counts.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (32'(cnt_q) >= START_TIMEOUT - 1) begin
          err_d[active_id_q] = 1'b1;
          last_grant_d       = active_id_q;
          state_d            = S_GAP;
          cnt_d              = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          ack_d[active_id_q] = 1'b1;
          last_grant_d       = active_id_q;
          state_d            = S_GAP;
          cnt_d              = '0;
        end
      end

      S_GAP: begin
        // The ack/err cycle is the first gap cycle; a zero gap still spends it.
        if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    ctrl_busy_d = (state_d != S_IDLE);
  end

  // NOTE: reset is sampled on the clock edge; every register, including the
  // datapath byte, is cleared so outputs read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      active_id_q  <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);  // requester 0 searched first
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      ctrl_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_id_q  <= active_id_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      ctrl_busy_q  <= ctrl_busy_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign active_id = active_id_q;
  assign ctrl_busy = ctrl_busy_q;

endmodule
